// File: rtl/alu_result_reader.sv
// Circular result store with a valid/ready burst readback port.
// Optional per-entry even parity is compiled in with `define ALUSTORE_PARITY_EN.
module alu_result_reader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_start,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW:0]      rd_len,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  input  logic             rd_ready,
  output logic             busy,
  output logic [AW:0]      count,
  output logic             full,
  output logic             err
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    load_addr;
  logic [AW:0]      remaining;
  logic [AW:0]      start_len;
  logic [WIDTH-1:0] load_data;
  logic             start_en;
  logic             load_en;
  logic             done;
  state_t           state;
  state_t           next_state;

  // NOTE: the storage array has no reset; the written flags make unwritten entries read as zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else if (wr_en) begin
      written[wr_ptr] <= 1'b1;
      wr_ptr          <= wr_ptr + 1'b1;
      if (count != DEPTH_CNT) count <= count + 1'b1;
    end
  end

  assign full = (count == DEPTH_CNT);

  // Reads see the array before this edge's write, so a same-entry collision yields the old value.
  assign load_data = written[load_addr] ? mem[load_addr] : '0;
  assign start_len = (rd_len > DEPTH_CNT) ? DEPTH_CNT : rd_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    start_en   = 1'b0;
    load_en    = 1'b0;
    done       = 1'b0;
    load_addr  = ptr + 1'b1;
    unique case (state)
      IDLE: begin
        if (rd_start && (rd_len != '0)) begin
          start_en   = 1'b1;
          load_en    = 1'b1;
          load_addr  = rd_addr;
          next_state = STREAM;
        end
      end
      STREAM: begin
        if (rd_ready) begin
          if (remaining > (AW+1)'(1)) begin
            load_en = 1'b1;
          end else begin
            done       = 1'b1;
            next_state = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      if (load_en) begin
        ptr       <= load_addr;
        rd_data   <= load_data;
        rd_valid  <= 1'b1;
        remaining <= start_en ? start_len : remaining - 1'b1;
      end else if (done) begin
        rd_valid <= 1'b0;
      end
    end
  end

  assign rd_last = rd_valid && (remaining == (AW+1)'(1));
  assign busy    = (state == STREAM);

`ifdef ALUSTORE_PARITY_EN
  logic par_mem [DEPTH];
  logic par_bad;

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_ptr] <= ^wr_data;
  end

  assign par_bad = written[load_addr] && ((^mem[load_addr]) != par_mem[load_addr]);

  // A fault on the first beat of a new burst wins over the clear from its rd_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err <= 1'b0;
    else if (load_en && par_bad) err <= 1'b1;
    else if (start_en)           err <= 1'b0;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_reader.sv
// Randomized bench for alu_result_reader against a queue/array model of the store.
module tb_alu_result_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_start;
  logic [2:0] rd_addr;
  logic [3:0] rd_len;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ready;
  logic       busy;
  logic [3:0] count;
  logic       full;
  logic       err;

  alu_result_reader #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_ready(rd_ready), .busy(busy), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [8];
  bit         m_wr  [8];
  int         m_wptr;
  int         m_count;

  function automatic logic [7:0] m_read(input int a);
    return m_wr[a % 8] ? m_mem[a % 8] : 8'h00;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin
      m_wr[i]  = 1'b0;
      m_mem[i] = 8'h00;
    end
    m_wptr  = 0;
    m_count = 0;
  endtask

  // One clock edge; the model absorbs the write that the edge samples.
  task automatic tick();
    @(posedge clk);
    if (wr_en) begin
      m_mem[m_wptr] = wr_data;
      m_wr[m_wptr]  = 1'b1;
      m_wptr        = (m_wptr + 1) % 8;
      if (m_count < 8) m_count++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_start = 1'b0;
    rd_addr = 3'd0; rd_len = 4'd0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_clear();
    rst_n = 1'b1;
  endtask

  task automatic write_val(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_count(input string tag);
    total++;
    if (count !== 4'(m_count) || full !== (m_count == 8)) begin
      bad++;
      $display("FAIL %s: count=%0d full=%b, expected count=%0d full=%b",
               tag, count, full, m_count, (m_count == 8));
    end
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready pattern 0,1,0,0,1,1.
  task automatic burst(input int addr, input int len, input int rmode,
                       input bit wr_rand, input bit ign);
    int n;
    int k;
    int cyc;
    bit r;
    logic [7:0] exp_d;
    bit pat [6];
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    n   = (len > 8) ? 8 : len;
    k   = 0;
    cyc = 0;
    rd_addr  = 3'(addr);
    rd_len   = 4'(len);
    rd_start = 1'b1;
    exp_d    = m_read(addr);
    tick();
    rd_start = 1'b0;
    if (!wr_rand) wr_en = 1'b0;
    if (n == 0) begin
      total++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL len_zero: valid=%b busy=%b, expected 0 0", rd_valid, busy);
      end
      return;
    end
    while (k < n && cyc < 300) begin
      total++;
      if (rd_valid !== 1'b1 || busy !== 1'b1 || rd_data !== exp_d || rd_last !== (k == n - 1)) begin
        bad++;
        $display("FAIL beat%0d addr=%0d len=%0d: valid=%b busy=%b data=%h last=%b, expected 1 1 %h %b",
                 k, addr, len, rd_valid, busy, rd_data, rd_last, exp_d, (k == n - 1));
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom);
        default: r = pat[cyc % 6];
      endcase
      rd_ready = r;
      if (wr_rand) begin
        wr_en   = 1'($urandom);
        wr_data = 8'($urandom);
      end
      if (ign) begin
        rd_start = 1'($urandom);
        rd_addr  = 3'($urandom);
        rd_len   = 4'($urandom_range(1, 15));
      end
      if (r && k < n - 1) exp_d = m_read(addr + k + 1);
      tick();
      if (r) k++;
      cyc++;
    end
    wr_en = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    if (k < n) begin
      total++; bad++;
      $display("FAIL burst_timeout: beats=%0d, expected %0d", k, n);
    end
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0) begin
      bad++;
      $display("FAIL burst_end: valid=%b busy=%b last=%b, expected 0 0 0", rd_valid, busy, rd_last);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({rd_valid, rd_data, rd_last, busy, count, full, err} !== 16'h0000) begin
      bad++;
      $display("FAIL reset: valid=%b data=%h last=%b busy=%b count=%0d full=%b err=%b, expected all 0",
               rd_valid, rd_data, rd_last, busy, count, full, err);
    end
  endtask

  task automatic test_unwritten();
    burst(0, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_write_read();
    write_val(8'h11); write_val(8'h22); write_val(8'h33); write_val(8'h44);
    check_count("count_after_4");
    burst(1, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_overwrite();
    do_reset();
    for (int i = 1; i <= 10; i++) write_val(8'(i));
    check_count("count_saturate");
    burst(6, 4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_corners();
    burst(5, 3, 2, 1'b0, 1'b0);
    burst(3, 0, 0, 1'b0, 1'b0);
    burst(2, 12, 0, 1'b0, 1'b0);
    burst(0, 5, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    burst(4, 2, 0, 1'b0, 1'b0);
    burst(7, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    int a;
    a = m_wptr;
    wr_en = 1'b1; wr_data = 8'hAB;
    burst(a, 2, 0, 1'b0, 1'b0);
    burst(a, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) write_val(8'($urandom));
      burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1,
            1'b1, 1'($urandom));
      check_count("count_random");
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL err_clean: err=%b, expected 0", err);
      end
    end
  endtask

  task automatic test_mid_reset();
    rd_ready = 1'b0; rd_addr = 3'd0; rd_len = 4'd8; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    total++;
    if (busy !== 1'b1 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_start: busy=%b valid=%b, expected 1 1", busy, rd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset_async: valid=%b busy=%b last=%b count=%0d, expected 0 0 0 0",
               rd_valid, busy, rd_last, count);
    end
    m_clear();
    rst_n = 1'b1;
    tick();
    burst(1, 2, 0, 1'b0, 1'b0);
  endtask

`ifdef ALUSTORE_PARITY_EN
  task automatic test_parity();
    do_reset();
    for (int i = 0; i < 4; i++) write_val(8'(8'h30 + i));
    dut.par_mem[2] = ~dut.par_mem[2];
    burst(1, 3, 0, 1'b0, 1'b0);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL parity_set: err=%b, expected 1", err);
    end
    burst(0, 1, 0, 1'b0, 1'b0);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL parity_clear: err=%b, expected 0", err);
    end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_unwritten();
    test_write_read();
    test_overwrite();
    test_corners();
    test_back_to_back();
    test_collision();
    test_random();
    test_mid_reset();
`ifdef ALUSTORE_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
